sfu_issue_sched: RTL
====================

# sfu_issue_sched

Issue scheduler in front of the SFU processing-element switch. It arbitrates round-robin among `NUM_REQS` issue slots and tracks in-flight operations per PE with credit counters. It also enforces serialization for ordering-sensitive ops (CSR writes, warp-control barriers): such an op issues only when the SFU is empty, and nothing else issues until it completes. It sits between the per-slot dispatch outputs and the PE switch; completion pulses come back from the PE result path.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesting issue slots (`ISSUE_WIDTH`).
- `PE_COUNT`, 2: number of SFU PEs (index 0 = WCTL, 1 = CSRS).
- `MAX_INFLIGHT`, 4: credit limit per PE, ≥1.
- Derived: `REQ_BITS = CLOG2(NUM_REQS)`, `PE_BITS = CLOG2(PE_COUNT)`, `CNT_BITS = CLOG2(MAX_INFLIGHT+1)`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQS  slot i has an op pending; must stay high until `req_ready[i]`.
- `req_pe_sel`  in  NUM_REQS*PE_BITS  target PE per slot; stable while valid.
- `req_serial`  in  NUM_REQS  op must execute alone; stable while valid.
- `req_ready`  out  NUM_REQS  one-hot grant acknowledge (= fire for that slot).
- `grant_valid`  out  1  a grant is presented to the PE switch.
- `grant_idx`  out  REQ_BITS  granted slot.
- `grant_pe_sel`  out  PE_BITS  PE of granted op.
- `grant_serial`  out  1  granted op is serial.
- `grant_ready`  in  1  PE switch accepts; fire = `grant_valid & grant_ready`.
- `done_valid`  in  PE_COUNT  one completion per PE per cycle.
- `inflight_cnt`  out  PE_COUNT*CNT_BITS  registered per-PE counters.
- `busy`  out  1  any counter nonzero or state ≠ RUN.

## Operation
- States: RUN, DRAIN, SERIAL. Reset → RUN, RR pointer 0, all counters 0, lock index 0.
- Eligibility in RUN: slot i is eligible if valid, and its PE counter < `MAX_INFLIGHT`, and (not serial, or all counters = 0). Counter values are the registered ones; there is no same-cycle bypass of `done_valid`.
- Arbitration: search starts at the RR pointer, over *valid* slots. Let the first valid slot be the candidate.
  - If the candidate is serial and some counter is nonzero: no grant, lock the candidate index, go to DRAIN.
  - Otherwise, grant the first *eligible* slot from the pointer.
- On fire, the pointer becomes granted index + 1, modulo `NUM_REQS`.
- A serial fire goes to SERIAL.
- DRAIN:
  - Grant only the locked slot, and only when all counters = 0.
  - On fire, go to SERIAL.
  - If the locked slot's `req_valid` drops (protocol violation), return to RUN.
- SERIAL:
  - No grants.
  - When the counter for the serial op's PE decrements to 0, return to RUN.
- Counters: +1 on fire to that PE, −1 on `done_valid` for that PE; both in the same cycle leaves it unchanged.
  - `done_valid` at count 0 is ignored (counter holds) and raises a simulation assertion.
  - A fire at `MAX_INFLIGHT` cannot occur by construction.
- `grant_valid` may be high without `grant_ready`. The grant may change on the next cycle only if a higher-priority slot becomes valid; the pointer does not move without a fire.

## Timing
- Grant path is combinational: request to `grant_valid`/`req_ready` has 0-cycle latency.
- Counters, state and pointer update on the `clk` edge after fire/done. `inflight_cnt` reflects an op one cycle after its fire.
- A credit freed by `done_valid` in cycle t makes that PE eligible in cycle t+1.
- SERIAL exit: done in cycle t puts the state in RUN at t+1, so the next grant is possible at t+1.
- DRAIN entry: the cycle after detection. The serial grant occurs in the first cycle after counters reach 0 with `grant_ready` high.
- Throughput: 1 grant per cycle maximum.
- Reset mid-operation: the next cycle shows all outputs idle (`grant_valid=0`, `req_ready=0`, `busy=0`, counters 0). In-flight completions arriving after reset are ignored per the underflow rule.

## Test plan
- **RR fairness.** `NUM_REQS=4`, all valid non-serial to PE0, `grant_ready=1`, `done_valid[0]=1` every cycle → grants in order 0,1,2,3,0; `inflight_cnt[0]` stays at 1.
- **Credit limit.** Slot 0 holds valid to PE1, no done → 4 grants on cycles 0–3; `grant_valid=0` on cycle 4. `done_valid[1]` at cycle 6 → grant at cycle 7.
- **Serial drain.** PE0 count 2, slot 1 serial valid at the pointer, slot 2 non-serial valid → state DRAIN and slot 2 not granted. Dones on cycles 3 and 4 → slot 1 granted at cycle 5, SERIAL. Its done at cycle 8 → slot 2 granted at cycle 9.
- **Backpressure.** `grant_ready=0` for 3 cycles with slot 2 valid → `grant_idx=2` held, pointer and counters unchanged; fire on cycle 4.
- **Simultaneous fire and done.** Same PE in the same cycle → counter unchanged. Done at count 0 → counter stays 0, assertion fires.
- **Reset mid-SERIAL.** `reset=1` for one cycle → `busy=0`, counters 0, state RUN, pointer 0. First grant after reset goes to the lowest valid index.

Source files
------------

// File: rtl/sfu_issue_sched.sv
// rtl/sfu_issue_sched.sv - round-robin SFU issue scheduler with per-PE credits
// Serial ops wait in DRAIN until every PE is idle, then block all issue until they complete.
module sfu_issue_sched #(
  parameter int NUM_REQS     = 4,
  parameter int PE_COUNT     = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int REQ_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int PE_BITS     = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
  localparam int CNT_BITS    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*PE_BITS-1:0]  req_pe_sel,
  input  logic [NUM_REQS-1:0]          req_serial,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic                         grant_valid,
  output logic [REQ_BITS-1:0]          grant_idx,
  output logic [PE_BITS-1:0]           grant_pe_sel,
  output logic                         grant_serial,
  input  logic                         grant_ready,
  input  logic [PE_COUNT-1:0]          done_valid,
  output logic [PE_COUNT*CNT_BITS-1:0] inflight_cnt,
  output logic                         busy
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SERIAL} state_t;

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t                state_q, state_d;
  logic [REQ_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_BITS-1:0]   lock_idx_q, lock_idx_d;
  logic [PE_BITS-1:0]    serial_pe_q, serial_pe_d;
  logic [CNT_BITS-1:0]   cnt_q [PE_COUNT];
  logic [CNT_BITS-1:0]   cnt_d [PE_COUNT];

  logic [PE_BITS-1:0]    slot_pe [NUM_REQS];
  logic [NUM_REQS-1:0]   eligible;
  logic                  all_zero;
  logic                  cand_found, elig_found, drain_hit, fire;
  logic [REQ_BITS-1:0]   cand_idx, elig_idx, gidx;
  logic                  gv;

  function automatic logic [REQ_BITS-1:0] wrap_add(input logic [REQ_BITS-1:0] base,
                                                   input int unsigned k);
    logic [REQ_BITS:0] s;
    s = {1'b0, base} + (REQ_BITS+1)'(k);
    if (s >= (REQ_BITS+1)'(NUM_REQS)) s = s - (REQ_BITS+1)'(NUM_REQS);
    return s[REQ_BITS-1:0];
  endfunction

  always_comb begin
    all_zero = 1'b1;
    for (int p = 0; p < PE_COUNT; p++) begin
      if (cnt_q[p] != '0) all_zero = 1'b0;
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      slot_pe[i]  = req_pe_sel[i*PE_BITS +: PE_BITS];
      eligible[i] = req_valid[i] && (cnt_q[slot_pe[i]] < MAX_CNT) &&
                    (!req_serial[i] || all_zero);
    end
  end

  // The first valid slot from the pointer decides whether a serial op forces a drain.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    elig_found = 1'b0;
    elig_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (req_valid[wrap_add(rr_ptr_q, k)] && !cand_found) begin
        cand_found = 1'b1;
        cand_idx   = wrap_add(rr_ptr_q, k);
      end
      if (eligible[wrap_add(rr_ptr_q, k)] && !elig_found) begin
        elig_found = 1'b1;
        elig_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    gv        = 1'b0;
    gidx      = '0;
    drain_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cand_found && req_serial[cand_idx] && !all_zero) begin
          drain_hit = 1'b1;
        end else if (elig_found) begin
          gv   = 1'b1;
          gidx = elig_idx;
        end
      end
      ST_DRAIN: begin
        if (req_valid[lock_idx_q] && all_zero) begin
          gv   = 1'b1;
          gidx = lock_idx_q;
        end
      end
      default: gv = 1'b0;
    endcase
  end

  always_comb begin
    grant_valid  = gv;
    grant_idx    = gidx;
    grant_pe_sel = gv ? slot_pe[gidx] : '0;
    grant_serial = gv & req_serial[gidx];
    fire         = gv & grant_ready;
    req_ready    = '0;
    if (fire) req_ready[gidx] = 1'b1;
    busy         = !all_zero || (state_q != ST_RUN);
    inflight_cnt = '0;
    for (int p = 0; p < PE_COUNT; p++) begin
      inflight_cnt[p*CNT_BITS +: CNT_BITS] = cnt_q[p];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    serial_pe_d = serial_pe_q;
    case (state_q)
      ST_RUN: begin
        if (drain_hit) begin
          state_d    = ST_DRAIN;
          lock_idx_d = cand_idx;
        end
      end
      ST_DRAIN: begin
        if (!req_valid[lock_idx_q]) state_d = ST_RUN;
      end
      default: begin
        if (done_valid[serial_pe_q] && (cnt_q[serial_pe_q] == CNT_ONE)) state_d = ST_RUN;
      end
    endcase
    if (fire) begin
      rr_ptr_d = wrap_add(gidx, 1);
      if (grant_serial || (state_q == ST_DRAIN)) begin
        state_d     = ST_SERIAL;
        serial_pe_d = grant_pe_sel;
      end
    end
  end

  // Completions on an idle PE are dropped so stale dones after reset cannot underflow.
  always_comb begin
    for (int p = 0; p < PE_COUNT; p++) begin
      cnt_d[p] = cnt_q[p];
      if ((fire && (grant_pe_sel == PE_BITS'(p))) && !(done_valid[p] && (cnt_q[p] != '0))) begin
        cnt_d[p] = cnt_q[p] + CNT_ONE;
      end else if (!(fire && (grant_pe_sel == PE_BITS'(p))) && done_valid[p] && (cnt_q[p] != '0)) begin
        cnt_d[p] = cnt_q[p] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      serial_pe_q <= '0;
      for (int p = 0; p < PE_COUNT; p++) cnt_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      serial_pe_q <= serial_pe_d;
      for (int p = 0; p < PE_COUNT; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  for (genvar g = 0; g < PE_COUNT; g++) begin : g_underflow_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(done_valid[g] && (cnt_q[g] == '0)))
      else $warning("sfu_issue_sched: done_valid on idle PE %0d dropped", g);
  end

endmodule
